// File: rtl/usb_fifo_sched.sv
// usb_fifo_sched -- slave-FIFO bus scheduler for the CY68013 (FX2).
//
// Shares the single 16-bit FX2 slave-FIFO bus between an RX path
// (EP2 -> rx_* stream) and a TX path (tx_* stream -> EP6). It generates the
// FIFOADDR / SLOE / SLRD / SLWR timing and arbitrates round-robin between the
// two directions, with bursts of at most BURST_MAX words per grant.
//
// Ports
//   fpga_gclk, reset_n       clock, async active-low reset
//   usb_flaga / usb_flagc    EP2 not empty / EP6 not full
//   usb_fifoaddr, usb_slcs,
//   usb_sloe, usb_slrd,
//   usb_slwr                 FX2 control pins (all registered)
//   usb_fd_i/_o/_oe          bus data in / out / FPGA drive enable
//   rx_data, rx_valid        word read from EP2, one-cycle valid pulse
//   rx_ready                 consumer can take the next word
//   tx_data, tx_valid        word to write to EP6
//   tx_ready                 one-cycle pulse when tx_data is captured
//   busy                     controller is not idle
module usb_fifo_sched #(
    parameter int SETUP_CYC  = 3,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int BURST_MAX  = 8
) (
    input  logic        fpga_gclk,
    input  logic        reset_n,
    input  logic        usb_flaga,
    input  logic        usb_flagc,
    output logic [1:0]  usb_fifoaddr,
    output logic        usb_slcs,
    output logic        usb_sloe,
    output logic        usb_slrd,
    output logic        usb_slwr,
    input  logic [15:0] usb_fd_i,
    output logic [15:0] usb_fd_o,
    output logic        usb_fd_oe,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        busy
);
    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W = $clog2(MAX_CYC) + 1;
    localparam int BC_W  = $clog2(BURST_MAX) + 1;

    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
    localparam logic [BC_W-1:0]  BURST_LAST  = BC_W'(BURST_MAX - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_SETUP  = 3'd1;
    localparam logic [2:0] S_RD_STROBE = 3'd2;
    localparam logic [2:0] S_RD_HOLD   = 3'd3;
    localparam logic [2:0] S_WR_SETUP  = 3'd4;
    localparam logic [2:0] S_WR_STROBE = 3'd5;
    localparam logic [2:0] S_WR_HOLD   = 3'd6;
    localparam logic [2:0] S_TURN      = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic             last_tx_q, last_tx_d;     // 1: last grant was TX
    logic [1:0]       fifoaddr_q, fifoaddr_d;
    logic             sloe_q, sloe_d;
    logic             slrd_q, slrd_d;
    logic             slwr_q, slwr_d;
    logic [15:0]      fd_o_q, fd_o_d;
    logic             fd_oe_q, fd_oe_d;
    logic [15:0]      rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             tx_ready_q, tx_ready_d;
    logic             busy_q, busy_d;

    logic rd_ok, wr_ok, grant_rd, grant_wr, rd_state, wr_state;

    assign rd_ok = usb_flaga & rx_ready;
    assign wr_ok = usb_flagc & tx_valid;
    // When both are eligible, the direction not granted last time wins.
    assign grant_rd = rd_ok & (~wr_ok | last_tx_q);
    assign grant_wr = wr_ok & (~rd_ok | ~last_tx_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        burst_cnt_d = burst_cnt_q;
        last_tx_d   = last_tx_q;
        fd_o_d      = fd_o_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_ready_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d       = '0;
                burst_cnt_d = '0;
                if (grant_rd) begin
                    state_d   = S_RD_SETUP;
                    last_tx_d = 1'b0;
                end else if (grant_wr) begin
                    state_d    = S_WR_SETUP;
                    last_tx_d  = 1'b1;
                    fd_o_d     = tx_data;
                    tx_ready_d = 1'b1;
                end
            end
            S_RD_SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = S_RD_STROBE;
                cnt_d   = '0;
            end
            S_RD_STROBE: if (cnt_q == STROBE_LAST) begin
                // Data is sampled on the edge that releases SLRD.
                state_d    = S_RD_HOLD;
                cnt_d      = '0;
                rx_data_d  = usb_fd_i;
                rx_valid_d = 1'b1;
            end
            S_RD_HOLD: if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                if (rd_ok && burst_cnt_q < BURST_LAST) begin
                    state_d     = S_RD_SETUP;
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end else begin
                    state_d     = S_TURN;
                    burst_cnt_d = '0;
                end
            end
            S_WR_SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = S_WR_STROBE;
                cnt_d   = '0;
            end
            S_WR_STROBE: if (cnt_q == STROBE_LAST) begin
                state_d = S_WR_HOLD;
                cnt_d   = '0;
            end
            S_WR_HOLD: if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                if (wr_ok && burst_cnt_q < BURST_LAST) begin
                    state_d     = S_WR_SETUP;
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                    fd_o_d      = tx_data;
                    tx_ready_d  = 1'b1;
                end else begin
                    state_d     = S_TURN;
                    burst_cnt_d = '0;
                end
            end
            S_TURN: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin controls are decoded from the next state and registered, so the
        // pads see glitch-free levels. A read and a write are always separated
        // by TURN, which keeps SLOE low and FD_OE high from ever overlapping.
        rd_state   = (state_d == S_RD_SETUP) || (state_d == S_RD_STROBE) || (state_d == S_RD_HOLD);
        wr_state   = (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) || (state_d == S_WR_HOLD);
        sloe_d     = ~rd_state;
        slrd_d     = (state_d != S_RD_STROBE);
        slwr_d     = (state_d != S_WR_STROBE);
        fd_oe_d    = wr_state;
        busy_d     = (state_d != S_IDLE);
        fifoaddr_d = rd_state ? 2'b00 : (wr_state ? 2'b10 : fifoaddr_q);
    end

    always_ff @(posedge fpga_gclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            burst_cnt_q <= '0;
            last_tx_q   <= 1'b1;
            fifoaddr_q  <= 2'b00;
            sloe_q      <= 1'b1;
            slrd_q      <= 1'b1;
            slwr_q      <= 1'b1;
            fd_o_q      <= '0;
            fd_oe_q     <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_tx_q   <= last_tx_d;
            fifoaddr_q  <= fifoaddr_d;
            sloe_q      <= sloe_d;
            slrd_q      <= slrd_d;
            slwr_q      <= slwr_d;
            fd_o_q      <= fd_o_d;
            fd_oe_q     <= fd_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign usb_fifoaddr = fifoaddr_q;
    assign usb_slcs     = 1'b0;
    assign usb_sloe     = sloe_q;
    assign usb_slrd     = slrd_q;
    assign usb_slwr     = slwr_q;
    assign usb_fd_o     = fd_o_q;
    assign usb_fd_oe    = fd_oe_q;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign tx_ready     = tx_ready_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_usb_fifo_sched.sv
`timescale 1ns/1ps
// Bench for usb_fifo_sched: a default-parameter instance (u0) and a
// BURST_MAX=1 instance (u1) share all inputs. Monitors turn the pin activity
// into word-level events; each test compares against expectations built from
// the arbitration/burst rules.
module tb_usb_fifo_sched;
    logic        fpga_gclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        usb_flaga = 1'b0, usb_flagc = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
    logic [15:0] usb_fd_i = '0, tx_data = '0;

    logic [1:0]  fifoaddr0, fifoaddr1;
    logic        slcs0, sloe0, slrd0, slwr0, fd_oe0, rx_valid0, tx_ready0, busy0;
    logic        slcs1, sloe1, slrd1, slwr1, fd_oe1, rx_valid1, tx_ready1, busy1;
    logic [15:0] fd_o0, rx_data0, fd_o1, rx_data1;

    int n_pass = 0, n_chk = 0;

    always #10 fpga_gclk = ~fpga_gclk;

    usb_fifo_sched u0 (
        .fpga_gclk(fpga_gclk), .reset_n(reset_n), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
        .usb_fifoaddr(fifoaddr0), .usb_slcs(slcs0), .usb_sloe(sloe0), .usb_slrd(slrd0),
        .usb_slwr(slwr0), .usb_fd_i(usb_fd_i), .usb_fd_o(fd_o0), .usb_fd_oe(fd_oe0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready0), .busy(busy0));

    usb_fifo_sched #(.BURST_MAX(1)) u1 (
        .fpga_gclk(fpga_gclk), .reset_n(reset_n), .usb_flaga(usb_flaga), .usb_flagc(usb_flagc),
        .usb_fifoaddr(fifoaddr1), .usb_slcs(slcs1), .usb_sloe(sloe1), .usb_slrd(slrd1),
        .usb_slwr(slwr1), .usb_fd_i(usb_fd_i), .usb_fd_o(fd_o1), .usb_fd_oe(fd_oe1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready1), .busy(busy1));

    // Fresh random bus data every cycle, changed well away from the edge.
    initial forever begin
        @(posedge fpga_gclk); #2;
        usb_fd_i = 16'($urandom);
    end

    // Present a new TX word after each capture.
    initial forever begin
        @(negedge fpga_gclk); #2;
        if (tx_ready0 || tx_ready1) tx_data = 16'($urandom);
    end

    // ---------------- monitors ----------------
    // Events: R = word read (rx_valid), W = word taken (tx_ready),
    //         T = turnaround cycle, I = return to idle.
    byte         ev0[$], ev1[$];
    logic [15:0] rd_exp_q[$], rx_got_q[$], wr_fd_q[$], tx_exp_q[$];
    int          rd_len_q[$], wr_len_q[$], oe_len_q[$];
    int          viol0 = 0, viol1 = 0, rv_misalign = 0, wr_strobes = 0;
    int          rd_run = 0, wr_run = 0, oe_run = 0;
    logic [15:0] rd_last = '0, wr_last = '0;
    logic        pslrd = 1'b1, pbusy0 = 1'b0, pbusy1 = 1'b0;

    always @(negedge fpga_gclk) begin
        if (!slrd0) begin
            rd_run++; rd_last = usb_fd_i;
        end else if (rd_run > 0) begin
            rd_len_q.push_back(rd_run); rd_exp_q.push_back(rd_last); rd_run = 0;
        end
        if (!slwr0) begin
            if (wr_run == 0) wr_strobes++;
            wr_run++; wr_last = fd_o0;
        end else if (wr_run > 0) begin
            wr_len_q.push_back(wr_run); wr_fd_q.push_back(wr_last); wr_run = 0;
        end
        if (fd_oe0) oe_run++;
        else if (oe_run > 0) begin oe_len_q.push_back(oe_run); oe_run = 0; end
        if (rx_valid0) begin
            rx_got_q.push_back(rx_data0); ev0.push_back("R");
            if (!(slrd0 && !pslrd)) rv_misalign++;
        end
        if (tx_ready0) begin tx_exp_q.push_back(tx_data); ev0.push_back("W"); end
        if (busy0 && sloe0 && slrd0 && slwr0 && !fd_oe0) ev0.push_back("T");
        if (pbusy0 && !busy0) ev0.push_back("I");
        if ((fd_oe0 && !sloe0) || (!slrd0 && sloe0) || (!slwr0 && !fd_oe0) ||
            (fd_oe0 && fifoaddr0 != 2'b10) || (!sloe0 && fifoaddr0 != 2'b00) || slcs0) viol0++;
        pslrd = slrd0; pbusy0 = busy0;

        if (rx_valid1) ev1.push_back("R");
        if (tx_ready1) ev1.push_back("W");
        if (busy1 && sloe1 && slrd1 && slwr1 && !fd_oe1) ev1.push_back("T");
        if (pbusy1 && !busy1) ev1.push_back("I");
        if ((fd_oe1 && !sloe1) || (!slrd1 && sloe1) || (!slwr1 && !fd_oe1)) viol1++;
        pbusy1 = busy1;
    end

    function automatic string ev_str(input byte q[$]);
        string s = "";
        foreach (q[i]) s = $sformatf("%s%c", s, q[i]);
        return s;
    endfunction

    task automatic tick();
        @(negedge fpga_gclk); #1;
    endtask

    task automatic clear_logs();
        ev0.delete(); ev1.delete(); rd_exp_q.delete(); rx_got_q.delete();
        wr_fd_q.delete(); tx_exp_q.delete(); rd_len_q.delete(); wr_len_q.delete(); oe_len_q.delete();
        viol0 = 0; viol1 = 0; rv_misalign = 0; wr_strobes = 0;
    endtask

    task automatic idle_inputs();
        usb_flaga = 1'b0; usb_flagc = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0; idle_inputs();
        #25;
        n_chk++; if ({fifoaddr0, slcs0, sloe0, slrd0, slwr0, fd_oe0} !== 7'b00_0_111_0)
            $display("FAIL reset_ctrl got %b exp 0001110", {fifoaddr0, slcs0, sloe0, slrd0, slwr0, fd_oe0}); else n_pass++;
        n_chk++; if (fd_o0 !== 16'h0) $display("FAIL reset_fd_o got %h exp 0000", fd_o0); else n_pass++;
        n_chk++; if (rx_data0 !== 16'h0) $display("FAIL reset_rx_data got %h exp 0000", rx_data0); else n_pass++;
        n_chk++; if ({rx_valid0, tx_ready0, busy0} !== 3'b000)
            $display("FAIL reset_pulses got %b exp 000", {rx_valid0, tx_ready0, busy0}); else n_pass++;
        @(negedge fpga_gclk); reset_n = 1'b1;
        repeat (2) tick();
        n_chk++; if (busy0 !== 1'b0 || slcs0 !== 1'b0) $display("FAIL reset_idle got busy=%b slcs=%b exp 0 0", busy0, slcs0); else n_pass++;
        clear_logs();
    endtask

    task automatic test_read_single();
        clear_logs();
        usb_flaga = 1'b1; rx_ready = 1'b1;
        for (int c = 0; c < 20 && sloe0; c++) tick();
        n_chk++; if (sloe0 !== 1'b0 || fifoaddr0 !== 2'b00)
            $display("FAIL rd1_grant got sloe=%b addr=%b exp 0 00", sloe0, fifoaddr0); else n_pass++;
        usb_flaga = 1'b0;
        for (int c = 0; c < 40 && ev0.size() < 3; c++) tick();
        n_chk++; if (rd_len_q.size() != 1 || rd_len_q[0] != 4)
            $display("FAIL rd1_strobe_len got n=%0d len=%0d exp 1 4", rd_len_q.size(), rd_len_q[0]); else n_pass++;
        n_chk++; if (rx_got_q.size() != 1 || rx_got_q[0] !== rd_exp_q[0])
            $display("FAIL rd1_data got n=%0d %h exp 1 %h", rx_got_q.size(), rx_got_q[0], rd_exp_q[0]); else n_pass++;
        n_chk++; if (ev_str(ev0) != "RTI") $display("FAIL rd1_events got %s exp RTI", ev_str(ev0)); else n_pass++;
        n_chk++; if (rv_misalign != 0 || viol0 != 0)
            $display("FAIL rd1_timing got misalign=%0d viol=%0d exp 0 0", rv_misalign, viol0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_write_single(input logic [15:0] data);
        clear_logs();
        tx_data = data; tx_valid = 1'b1; usb_flagc = 1'b1;
        for (int c = 0; c < 20 && ev0.size() < 1; c++) tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 40 && ev0.size() < 3; c++) tick();
        n_chk++; if (ev_str(ev0) != "WTI") $display("FAIL wr1_events got %s exp WTI", ev_str(ev0)); else n_pass++;
        n_chk++; if (wr_len_q.size() != 1 || wr_len_q[0] != 4 || oe_len_q.size() != 1 || oe_len_q[0] != 9)
            $display("FAIL wr1_lengths got slwr=%0d oe=%0d exp 4 9", wr_len_q[0], oe_len_q[0]); else n_pass++;
        n_chk++; if (wr_fd_q.size() != 1 || wr_fd_q[0] !== data || tx_exp_q[0] !== data)
            $display("FAIL wr1_data got fd=%h cap=%h exp %h", wr_fd_q[0], tx_exp_q[0], data); else n_pass++;
        n_chk++; if (viol0 != 0) $display("FAIL wr1_safety got viol=%0d exp 0", viol0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_read_burst();
        string e = "";
        int bad = 0;
        clear_logs();
        usb_flaga = 1'b1; rx_ready = 1'b1;
        for (int c = 0; c < 300 && ev0.size() < 11; c++) tick();
        usb_flaga = 1'b0;
        for (int c = 0; c < 60 && busy0; c++) tick();
        tick();
        for (int i = 0; i < 8; i++) e = {e, "R"};
        e = {e, "TIRTI"};
        n_chk++; if (ev_str(ev0) != e) $display("FAIL burst_events got %s exp %s", ev_str(ev0), e); else n_pass++;
        foreach (rx_got_q[i]) if (i >= rd_exp_q.size() || rx_got_q[i] !== rd_exp_q[i] || rd_len_q[i] != 4) bad++;
        n_chk++; if (rx_got_q.size() != 9 || bad != 0)
            $display("FAIL burst_data got words=%0d bad=%0d exp 9 0", rx_got_q.size(), bad); else n_pass++;
        n_chk++; if (viol0 != 0 || rv_misalign != 0) $display("FAIL burst_safety got viol=%0d exp 0", viol0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_write_stop(input int k);
        string e = "";
        int bad = 0;
        clear_logs();
        tx_data = 16'($urandom); tx_valid = 1'b1; usb_flagc = 1'b1;
        for (int c = 0; c < 200 && wr_strobes < k; c++) tick();
        usb_flagc = 1'b0;
        for (int c = 0; c < 60 && busy0; c++) tick();
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < k; i++) e = {e, "W"};
        e = {e, "TI"};
        n_chk++; if (ev_str(ev0) != e) $display("FAIL wrstop_events k=%0d got %s exp %s", k, ev_str(ev0), e); else n_pass++;
        foreach (tx_exp_q[i]) if (i >= wr_fd_q.size() || wr_fd_q[i] !== tx_exp_q[i] || wr_len_q[i] != 4) bad++;
        n_chk++; if (wr_fd_q.size() != k || bad != 0)
            $display("FAIL wrstop_data got words=%0d bad=%0d exp %0d 0", wr_fd_q.size(), bad, k); else n_pass++;
        n_chk++; if (viol0 != 0) $display("FAIL wrstop_safety got viol=%0d exp 0", viol0); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_alternate();
        string e1 = "", e0 = "";
        byte dir;
        @(negedge fpga_gclk); reset_n = 1'b0;
        tick(); reset_n = 1'b1; tick();
        clear_logs();
        usb_flaga = 1'b1; rx_ready = 1'b1; usb_flagc = 1'b1; tx_valid = 1'b1;
        for (int c = 0; c < 600 && (ev1.size() < 18 || ev0.size() < 20); c++) tick();
        idle_inputs();
        for (int c = 0; c < 200 && (busy0 || busy1); c++) tick();
        // Reset leaves last_grant=TX, so the first contended grant is RX.
        dir = "R";
        for (int g = 0; g < 6; g++) begin
            e1 = $sformatf("%s%cTI", e1, dir);
            dir = (dir == "R") ? "W" : "R";
        end
        dir = "R";
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 8; i++) e0 = $sformatf("%s%c", e0, dir);
            e0 = {e0, "TI"};
            dir = (dir == "R") ? "W" : "R";
        end
        n_chk++; if (ev1.size() < 18 || ev_str(ev1).substr(0, 17) != e1)
            $display("FAIL alt_b1_events got %s exp %s...", ev_str(ev1), e1); else n_pass++;
        n_chk++; if (ev0.size() < 20 || ev_str(ev0).substr(0, 19) != e0)
            $display("FAIL alt_b8_events got %s exp %s...", ev_str(ev0), e0); else n_pass++;
        n_chk++; if (viol1 != 0 || viol0 != 0)
            $display("FAIL alt_safety got viol1=%0d viol0=%0d exp 0 0", viol1, viol0); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        logic [15:0] d;
        clear_logs();
        tx_data = 16'($urandom); tx_valid = 1'b1; usb_flagc = 1'b1;
        for (int c = 0; c < 30 && slwr0; c++) tick();
        reset_n = 1'b0;
        #1;
        n_chk++; if ({slwr0, fd_oe0, busy0} !== 3'b100 || fd_o0 !== 16'h0)
            $display("FAIL rstmid_async got slwr=%b oe=%b busy=%b fd=%h exp 1 0 0 0000", slwr0, fd_oe0, busy0, fd_o0); else n_pass++;
        tx_valid = 1'b0;
        repeat (3) tick();
        @(negedge fpga_gclk); reset_n = 1'b1;
        repeat (3) tick();
        n_chk++; if (busy0 !== 1'b0 || ev_str(ev0) != "WI")
            $display("FAIL rstmid_idle got busy=%b ev=%s exp 0 WI", busy0, ev_str(ev0)); else n_pass++;
        d = 16'($urandom); tx_data = d; tx_valid = 1'b1;
        for (int c = 0; c < 20 && ev0.size() < 3; c++) tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 40 && ev0.size() < 5; c++) tick();
        n_chk++; if (ev_str(ev0) != "WIWTI") $display("FAIL rstmid_resume got %s exp WIWTI", ev_str(ev0)); else n_pass++;
        n_chk++; if (wr_fd_q.size() == 0 || wr_fd_q[wr_fd_q.size()-1] !== d)
            $display("FAIL rstmid_data got %h exp %h", (wr_fd_q.size() == 0) ? 16'h0 : wr_fd_q[wr_fd_q.size()-1], d); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_read_single();
        test_write_single(16'hA55A);
        test_write_single(16'($urandom));
        test_read_burst();
        test_write_stop(3);
        test_write_stop(int'($urandom_range(1, 7)));
        test_alternate();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
